// File: rtl/cpu_bus_pkg.sv
// Shared definitions for blocks on the CPU bus: the bus width, the fetch FSM
// states and the polarity of active-low controls.
package cpu_bus_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic ACTIVE_LOW_ASSERT = 1'b0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_READ  = 2'd1,
    FETCH_ERROR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/bus_tristate_driver.sv
// Tri-state driver for the shared CPU bus. It drives i_DATA only while
// i_ENABLE_n is asserted. The PC and other bus producers reuse it.
module bus_tristate_driver
  import cpu_bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_ENABLE_n,
  inout  wire  [DATA_WIDTH-1:0] BUS
);

  assign BUS = (i_ENABLE_n == ACTIVE_LOW_ASSERT) ? i_DATA : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/instruction_fetch_register.sv
// Instruction fetch register. It captures an address from the CPU bus and
// reads instruction memory with a bounded wait. It latches the returned word
// and drives that word back onto the bus when asked.
module instruction_fetch_register
  import cpu_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = BUS_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_CLOCK,
  input  logic                  i_RESET,
  inout  wire  [DATA_WIDTH-1:0] BUS,
  input  logic                  i_LOAD_n,
  input  logic                  i_FETCH,
  input  logic                  i_OUTPUT_n,
  output logic [DATA_WIDTH-1:0] o_MEM_ADDR,
  output logic                  o_MEM_RD,
  input  logic                  i_MEM_READY,
  input  logic [DATA_WIDTH-1:0] i_MEM_DATA,
  output logic                  o_BUSY,
  output logic                  o_VALID,
  output logic                  o_ERROR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  valid_q;
  logic                  error_q;
  logic                  load;

  assign load = (i_LOAD_n == ACTIVE_LOW_ASSERT);

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q <= FETCH_IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_IDLE, FETCH_ERROR: begin
          // A load and a fetch at the same edge both take effect. The read
          // then uses the new address, because o_MEM_ADDR comes from addr_q.
          if (load) begin
            addr_q  <= BUS;
            valid_q <= 1'b0;
          end
          if (i_FETCH) begin
            state_q <= FETCH_READ;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
          end else if (state_q == FETCH_ERROR && load) begin
            state_q <= FETCH_IDLE;
            error_q <= 1'b0;
          end
        end
        FETCH_READ: begin
          if (i_MEM_READY) begin
            instr_q <= i_MEM_DATA;
            valid_q <= 1'b1;
            state_q <= FETCH_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= FETCH_ERROR;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

  assign o_MEM_ADDR = addr_q;
  assign o_MEM_RD   = (state_q == FETCH_READ);
  assign o_BUSY     = (state_q == FETCH_READ);
  assign o_VALID    = valid_q;
  assign o_ERROR    = error_q;

  bus_tristate_driver #(.DATA_WIDTH(DATA_WIDTH)) u_bus_drv (
    .i_DATA     (instr_q),
    .i_ENABLE_n (i_OUTPUT_n),
    .BUS        (BUS)
  );

endmodule

// File: tb/tb_instruction_fetch_register.sv
// Bench for instruction_fetch_register. It runs directed fetch scenarios and
// then random ones, checked against a transaction-level expectation.
module tb_instruction_fetch_register;

  localparam int W = 32;
  localparam int T = 16;

  logic         i_CLOCK = 1'b0;
  logic         i_RESET;
  wire  [W-1:0] BUS;
  logic         i_LOAD_n, i_FETCH, i_OUTPUT_n, i_MEM_READY;
  logic [W-1:0] i_MEM_DATA, o_MEM_ADDR;
  logic         o_MEM_RD, o_BUSY, o_VALID, o_ERROR;

  logic [W-1:0] tb_bus;
  logic         tb_bus_en;
  assign BUS = tb_bus_en ? tb_bus : {W{1'bz}};

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_instr;

  always #5 i_CLOCK = ~i_CLOCK;

  instruction_fetch_register #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .i_CLOCK     (i_CLOCK),
    .i_RESET     (i_RESET),
    .BUS         (BUS),
    .i_LOAD_n    (i_LOAD_n),
    .i_FETCH     (i_FETCH),
    .i_OUTPUT_n  (i_OUTPUT_n),
    .o_MEM_ADDR  (o_MEM_ADDR),
    .o_MEM_RD    (o_MEM_RD),
    .i_MEM_READY (i_MEM_READY),
    .i_MEM_DATA  (i_MEM_DATA),
    .o_BUSY      (o_BUSY),
    .o_VALID     (o_VALID),
    .o_ERROR     (o_ERROR)
  );

  task automatic step();
    @(posedge i_CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input logic [W-1:0] exp);
    tb_bus_en  = 1'b0;
    i_OUTPUT_n = 1'b0;
    #1;
    chk("bus_out", BUS, exp);
    i_OUTPUT_n = 1'b1;
    #1;
  endtask

  // A fetch whose memory answers in READ cycle `lat` succeeds when lat < T.
  // Otherwise it times out after exactly T READ cycles.
  task automatic run_fetch(input logic [W-1:0] addr, input int lat, input logic [W-1:0] data,
                           input bit do_load, input bit same_edge, input bit disturb);
    int  rd_cycles;
    bit  ok;
    logic [W-1:0] exp_addr;
    exp_addr = do_load ? addr : o_MEM_ADDR;
    if (do_load) begin
      tb_bus = addr; tb_bus_en = 1'b1; i_LOAD_n = 1'b0; i_FETCH = same_edge;
      step();
      i_LOAD_n = 1'b1; tb_bus_en = 1'b0;
      chk("load_addr", o_MEM_ADDR, addr);
      chk("load_err_clear", o_ERROR, 1'b0);
      if (!same_edge) chk("load_valid_clear", o_VALID, 1'b0);
    end
    if (!(do_load && same_edge)) begin
      i_FETCH = 1'b1;
      step();
    end
    i_FETCH = 1'b0;
    chk("read_entry_busy", o_BUSY, 1'b1);
    chk("read_entry_err", o_ERROR, 1'b0);
    chk("read_entry_valid", o_VALID, 1'b0);
    rd_cycles = 0;
    for (int k = 0; k < 3 * T && o_MEM_RD; k++) begin
      rd_cycles++;
      chk("read_addr", o_MEM_ADDR, exp_addr);
      i_MEM_READY = (k == lat);
      i_MEM_DATA  = (k == lat) ? data : $urandom;
      if (disturb && k == 0) begin
        tb_bus = 32'hFFFF_FFFF; tb_bus_en = 1'b1; i_LOAD_n = 1'b0; i_FETCH = 1'b1;
      end else begin
        tb_bus_en = 1'b0; i_LOAD_n = 1'b1; i_FETCH = 1'b0;
      end
      step();
    end
    i_MEM_READY = 1'b0; tb_bus_en = 1'b0; i_LOAD_n = 1'b1; i_FETCH = 1'b0;
    ok = (lat < T);
    if (ok) m_instr = data;
    chk("rd_cycles", rd_cycles, ok ? lat + 1 : T);
    chk("done_valid", o_VALID, ok);
    chk("done_error", o_ERROR, !ok);
    chk("done_busy", o_BUSY, 1'b0);
    chk("done_addr", o_MEM_ADDR, exp_addr);
    chk_bus(m_instr);
  endtask

  initial begin
    i_RESET = 1'b1; i_LOAD_n = 1'b1; i_FETCH = 1'b0; i_OUTPUT_n = 1'b1;
    i_MEM_READY = 1'b0; i_MEM_DATA = '0; tb_bus = '0; tb_bus_en = 1'b0;
    m_instr = '0;
    step(); step();
    i_RESET = 1'b0;
    step();
    chk("rst_valid", o_VALID, 1'b0);
    chk("rst_error", o_ERROR, 1'b0);
    chk("rst_rd", o_MEM_RD, 1'b0);
    chk("rst_busy", o_BUSY, 1'b0);
    chk("rst_addr", o_MEM_ADDR, '0);
    chk_bus('0);

    // Memory answers in the third READ cycle.
    run_fetch(32'h0000_0040, 2, 32'hDEAD_BEEF, 1, 0, 0);
    // Load and fetch at the same edge, with a zero-wait memory.
    run_fetch(32'h0000_0100, 0, 32'h1234_5678, 1, 1, 0);
    // Timeout, then a retry with fetch only.
    run_fetch(32'h0000_0040, T + 5, 32'h0BAD_0BAD, 1, 0, 0);
    run_fetch(32'h0000_0000, 1, 32'hCAFE_F00D, 0, 0, 0);
    // Timeout, then a load-only exit from ERROR followed by a normal fetch.
    run_fetch(32'h0000_0080, T + 1, 32'h0, 0, 0, 0);
    run_fetch(32'h0000_0040, 2, 32'h5555_1111, 1, 0, 0);
    // Load and fetch pulses during READ must be ignored.
    run_fetch(32'h0000_0040, 3, 32'h7777_8888, 1, 0, 1);

    // Reset in the second READ cycle aborts the read, and a late ready is ignored.
    i_FETCH = 1'b1; step(); i_FETCH = 1'b0;
    step();
    i_RESET = 1'b1; step(); i_RESET = 1'b0;
    i_MEM_READY = 1'b1; i_MEM_DATA = 32'hAAAA_AAAA;
    chk("rstmid_rd", o_MEM_RD, 1'b0);
    chk("rstmid_valid", o_VALID, 1'b0);
    chk("rstmid_addr", o_MEM_ADDR, '0);
    step();
    i_MEM_READY = 1'b0;
    chk("rstmid_late_valid", o_VALID, 1'b0);
    chk("rstmid_late_busy", o_BUSY, 1'b0);
    m_instr = '0;
    chk_bus(m_instr);

    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] a, d;
      int lat;
      a   = $urandom;
      d   = $urandom;
      lat = $urandom_range(0, T + 3);
      run_fetch(a, lat, d, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 && lat > 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
